// File: rtl/seven_segment_scan.sv
// Time-multiplexed scanner for a 4-digit common-anode seven-segment display.
// Picks one nibble per refresh slot for the downstream seven_segment decoder
// and drives the active-low anode and decimal-point pins directly. Inputs are
// captured once per frame so a digit never changes value mid-frame.
// No handshakes here: inputs are level signals sampled only at the frame
// boundary, and outputs are plain registered-state decodes with no valid/ready.
module seven_segment_scan #(
  parameter int REFRESH_DIV = 100000,
  parameter int LZ_BLANK    = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] data_in,
  input  logic [3:0]  blank_in,
  input  logic [3:0]  dp_in,
  output logic [3:0]  digit_data,
  output logic [3:0]  anode,
  output logic        dp_n,
  output logic        frame_start
);

  localparam int              CNT_W   = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       sel_q, sel_d;
  logic [15:0]      data_q;
  logic [3:0]       blank_q;
  logic [3:0]       dp_q;
  logic             tick;
  logic             snap;
  logic [3:0]       lz;
  logic [3:0]       eff_blank;
  logic             cur_blank;

  // Slot timing: tick ends a digit slot; the last slot of a frame also snapshots.
  always_comb begin
    tick = (cnt_q == CNT_MAX);
    snap = tick && (sel_q == 2'd3);
  end

  // Next-state: counter wraps at the end of a slot, digit select advances on tick.
  always_comb begin
    cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
    sel_d = tick ? sel_q + 2'd1 : sel_q;
  end

  // State register; the snapshot loads on the same edge that returns to digit 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      sel_q   <= 2'd0;
      data_q  <= 16'h0000;
      blank_q <= 4'h0;
      dp_q    <= 4'h0;
    end else begin
      cnt_q <= cnt_d;
      sel_q <= sel_d;
      if (snap) begin
        data_q  <= data_in;
        blank_q <= blank_in;
        dp_q    <= dp_in;
      end
    end
  end

  // Leading-zero suppression: a digit is dark when it and every higher nibble are zero.
  always_comb begin
    lz = 4'b0000;
    if (LZ_BLANK != 0) begin
      lz[3] = (data_q[15:12] == 4'h0);
      lz[2] = (data_q[15:8]  == 8'h00);
      lz[1] = (data_q[15:4]  == 12'h000);
    end
    eff_blank = blank_q | lz;
  end

  // Output decode from registered state only; nibble is driven even when blanked.
  always_comb begin
    digit_data = 4'h0;
    case (sel_q)
      2'd0: digit_data = data_q[3:0];
      2'd1: digit_data = data_q[7:4];
      2'd2: digit_data = data_q[11:8];
      2'd3: digit_data = data_q[15:12];
      default: digit_data = 4'h0;
    endcase
    cur_blank   = eff_blank[sel_q];
    anode       = cur_blank ? 4'b1111 : ~(4'b0001 << sel_q);
    dp_n        = ~(dp_q[sel_q] & ~cur_blank);
    frame_start = snap;
  end

endmodule

// File: tb/tb_seven_segment_scan.sv
// Directed bench for seven_segment_scan with REFRESH_DIV=4. Two instances share
// all inputs: one without and one with leading-zero suppression. Each table
// record describes one full frame: inputs applied at the preceding frame_start
// and hand-computed anode / nibble / point values per digit slot.
module tb_seven_segment_scan;

  logic        clk;
  logic        rst_n;
  logic [15:0] data_in;
  logic [3:0]  blank_in;
  logic [3:0]  dp_in;
  logic [3:0]  digit_data0, anode0, digit_data1, anode1;
  logic        dp_n0, frame_start0, dp_n1, frame_start1;

  int n_chk  = 0;
  int n_fail = 0;

  seven_segment_scan #(.REFRESH_DIV(4), .LZ_BLANK(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .blank_in(blank_in), .dp_in(dp_in),
    .digit_data(digit_data0), .anode(anode0), .dp_n(dp_n0), .frame_start(frame_start0)
  );

  seven_segment_scan #(.REFRESH_DIV(4), .LZ_BLANK(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .blank_in(blank_in), .dp_in(dp_in),
    .digit_data(digit_data1), .anode(anode1), .dp_n(dp_n1), .frame_start(frame_start1)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One frame of expectations. an/dig pack digit 3..0 as nibbles [15:12]..[3:0];
  // dpn holds the expected dp_n for digits 3..0.
  typedef struct {
    logic [15:0] data;
    logic [3:0]  blank;
    logic [3:0]  dp;
    bit          lz;
    bit          apply;
    bit          chg;
    logic [15:0] chg_data;
    logic [15:0] an;
    logic [15:0] dig;
    logic [3:0]  dpn;
  } vec_t;

  vec_t vecs[11];
  vec_t rf;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Checks 16 consecutive states starting at the current one (digit 0, slot start).
  task automatic run_frame(input vec_t v);
    logic [3:0] a_act, d_act;
    logic       p_act, f_act;
    int         d;
    for (int p = 0; p < 16; p++) begin
      if (p > 0) step();
      if (v.chg && p == 4) data_in = v.chg_data;
      d     = p / 4;
      a_act = v.lz ? anode1 : anode0;
      d_act = v.lz ? digit_data1 : digit_data0;
      p_act = v.lz ? dp_n1 : dp_n0;
      f_act = v.lz ? frame_start1 : frame_start0;
      chk("anode", a_act, v.an[4*d +: 4]);
      chk("digit_data", d_act, v.dig[4*d +: 4]);
      chk("dp_n", {3'b000, p_act}, {3'b000, v.dpn[d]});
      chk("frame_start", {3'b000, f_act}, {3'b000, (p == 15)});
    end
  endtask

  initial begin
    //             data      blank    dp       lz    apply chg   chg_data  an        dig       dpn
    vecs[0]  = '{16'h1234, 4'b0000, 4'b0010, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h7BDE, 16'h1234, 4'b1101};
    vecs[1]  = '{16'h1234, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b1, 16'hABCD, 16'h7BDE, 16'h1234, 4'b1111};
    vecs[2]  = '{16'hABCD, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h7BDE, 16'hABCD, 4'b1111};
    vecs[3]  = '{16'hABCD, 4'b0100, 4'b0100, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h7FDE, 16'hABCD, 4'b1111};
    vecs[4]  = '{16'h5678, 4'b1000, 4'b1001, 1'b0, 1'b1, 1'b0, 16'h0000, 16'hFBDE, 16'h5678, 4'b1110};
    vecs[5]  = '{16'h0050, 4'b0000, 4'b0000, 1'b1, 1'b1, 1'b0, 16'h0000, 16'hFFDE, 16'h0050, 4'b1111};
    vecs[6]  = '{16'h0000, 4'b0000, 4'b0000, 1'b1, 1'b1, 1'b0, 16'h0000, 16'hFFFE, 16'h0000, 4'b1111};
    vecs[7]  = '{16'h0501, 4'b0000, 4'b0000, 1'b1, 1'b1, 1'b0, 16'h0000, 16'hFBDE, 16'h0501, 4'b1111};
    vecs[8]  = '{16'h0501, 4'b0000, 4'b1111, 1'b1, 1'b1, 1'b0, 16'h0000, 16'hFBDE, 16'h0501, 4'b1000};
    vecs[9]  = '{16'h0050, 4'b0001, 4'b0001, 1'b1, 1'b1, 1'b0, 16'h0000, 16'hFFDF, 16'h0050, 4'b1111};
    vecs[10] = '{16'h0050, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h7BDE, 16'h0050, 4'b1111};
    // Frame right after reset: all-zero snapshot, plain rotation, no points.
    rf       = '{16'h0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h7BDE, 16'h0000, 4'b1111};

    // Reset held for 3 cycles with busy inputs
    rst_n    = 1'b0;
    data_in  = 16'hFFFF;
    blank_in = 4'hF;
    dp_in    = 4'hF;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_anode", anode0, 4'b1110);
    chk("rst_digit_data", digit_data0, 4'h0);
    chk("rst_dp_n", {3'b000, dp_n0}, 4'b0001);
    chk("rst_frame_start", {3'b000, frame_start0}, 4'b0000);
    chk("rst_anode_lz", anode1, 4'b1110);

    // First frame after release still shows the cleared snapshot
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    run_frame(rf);

    // Table frames: inputs applied during the frame_start cycle
    for (int k = 0; k < 11; k++) begin
      if (vecs[k].apply) begin
        data_in  = vecs[k].data;
        blank_in = vecs[k].blank;
        dp_in    = vecs[k].dp;
      end
      step();
      run_frame(vecs[k]);
    end

    // Asynchronous reset between edges during the digit-2 slot
    step();
    repeat (8) step();
    chk("pre_async_anode", anode0, 4'b1011);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_anode", anode0, 4'b1110);
    chk("async_digit_data", digit_data0, 4'h0);
    chk("async_dp_n", {3'b000, dp_n0}, 4'b0001);
    chk("async_frame_start", {3'b000, frame_start0}, 4'b0000);
    chk("async_anode_lz", anode1, 4'b1110);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    run_frame(rf);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
